fifo_word_packer: RTL and testbench
===================================

# fifo_word_packer

Downstream drain stage for the 16x8 synchronous FIFO: pops bytes from the FIFO's read port and packs them into 32-bit words presented on a valid/ready output. Captures every popped byte the cycle after it issues the pop, keeps reading back-to-back for full throughput, and supports a flush that emits a partial word with a byte-keep mask.

## Interface
- DATA_WIDTH, 8, FIFO byte width.
- WORD_BYTES, 4, bytes per output word; out_data is DATA_WIDTH*WORD_BYTES bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after a pop is issued.
- fifo_rd_en  out  1  pop request to FIFO.
- flush  in  1  single-cycle request to emit any held partial word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts word when out_valid && out_ready at a rising edge.
- out_data  out  DATA_WIDTH*WORD_BYTES  packed word; first-popped byte in bits [7:0].
- out_keep  out  WORD_BYTES  per-byte valid mask for out_data.

## Operation
- State: assembly register (WORD_BYTES bytes), held count (0..WORD_BYTES), inflight flag (registered fifo_rd_en), flush_pend flag, output register (out_data/out_keep/out_valid).
- out_free = !out_valid || out_ready.
- fifo_rd_en (combinational) = !rst && !fifo_empty && !flush_pend && ((held+inflight < WORD_BYTES) || (held+inflight == WORD_BYTES && out_free)). A popped byte always has a slot when it returns; no byte is ever dropped.
- Capture: when inflight=1, fifo_data is written to assembly slot [held], held increments.
- Word complete (held==WORD_BYTES, or capture fills the last slot) and out_free: load output register with the full word, out_keep all ones, out_valid=1, held cleared in the same edge. If !out_free the word waits in assembly; reads stop.
- Output register: cleared out_valid on accept with no new load; a new load in the accept cycle overwrites directly (no bubble).
- flush pulse sets flush_pend (sticky); new pops blocked while set. Once inflight=0: held>0 and out_free → load partial word, out_keep = low held bits set, unused out_data bytes zero, held and flush_pend cleared; held==0 → flush_pend cleared, nothing emitted.
- Full-word completion in same cycle as flush: full word emitted first; flush then resolves on held=0 (no extra word).
- FIFO empty mid-word: held bytes retained indefinitely until more data or flush.

## Timing
- Reset (async): out_valid=0, out_data=0, out_keep=0, held=0, inflight=0, flush_pend=0; fifo_rd_en=0 while rst high.
- Pop latency: byte popped in cycle t captured at edge ending t+1.
- First-word latency: pops in cycles t..t+3 → out_valid high in cycle t+5.
- Throughput: with FIFO non-empty and out_ready held 1, fifo_rd_en stays high continuously; one word per 4 cycles.
- Backpressure: out_ready=0 with word held in output and a full word in assembly → fifo_rd_en=0 until out_ready=1; resumes the same cycle out_ready rises.
- Flush latency: flush in cycle t with no inflight and out_free → partial word valid in cycle t+2 (flush_pend registered at t, load at edge ending t+1).
- Reset mid-word or mid-flush discards all held and output data immediately.

## Test plan
- Write 101..108 into FIFO, out_ready=1 → two words 0x68676665, 0x6C6B6A69 (bytes 104..101, 108..105), keep=4'b1111, fifo_rd_en continuous for 8 cycles.
- Write 16 bytes 101..116, out_ready=0 → after 8 pops fifo_rd_en drops; raise out_ready → 4 words in order, no byte lost or duplicated, FIFO ends empty.
- Write 160,161,162 then flush → one word out_data=0x00A2A1A0, out_keep=4'b0111.
- Flush with FIFO empty and held=0 → out_valid stays 0, flush_pend clears within 2 cycles.
- Flush asserted the cycle the 4th byte is captured → single full word keep=4'b1111, no trailing empty word.
- Assert rst while 2 bytes held and out_valid=1 → out_valid/out_data/out_keep 0 immediately; subsequent 4 bytes form a clean new word.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Drains bytes from a synchronous FIFO read port and packs them into words on a
// valid/ready output; a flush emits any held partial word with a byte-keep mask.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] out_data,
    output logic [WORD_BYTES-1:0]            out_keep
);

    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] WB_CNT = CW'(WORD_BYTES);
    localparam logic [CW:0]   WB_OCC = (CW + 1)'(WORD_BYTES);

    logic [WORD_BYTES-1:0][DATA_WIDTH-1:0] asm_q, asm_d;
    logic [CW-1:0]                         held_q, held_d;
    logic                                  inflight_q;
    logic                                  flush_pend_q, flush_pend_d;
    logic [DATA_WIDTH*WORD_BYTES-1:0]      out_data_q, out_data_d;
    logic [WORD_BYTES-1:0]                 out_keep_q, out_keep_d;
    logic                                  out_valid_q, out_valid_d;

    logic                                  out_free;
    logic [CW:0]                           occ;
    logic [CW-1:0]                         held_cap;
    logic                                  word_done;
    logic                                  flush_ready;
    logic [DATA_WIDTH*WORD_BYTES-1:0]      part_data;
    logic [WORD_BYTES-1:0]                 part_keep;

    // Partial word is only formed with nothing in flight, so the registered
    // assembly contents and count are already final.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_part
            localparam logic [CW-1:0] IDX = CW'(gi);
            assign part_keep[gi] = (held_q > IDX);
            assign part_data[gi*DATA_WIDTH +: DATA_WIDTH] = part_keep[gi] ? asm_q[gi] : '0;
        end
    endgenerate

    always_comb begin
        out_free = !out_valid_q || out_ready;
        occ      = {1'b0, held_q} + {{CW{1'b0}}, inflight_q};
        // Only pop when the returning byte is guaranteed a slot.
        fifo_rd_en = !rst && !fifo_empty && !flush_pend_q &&
                     ((occ < WB_OCC) || ((occ == WB_OCC) && out_free));

        asm_d = asm_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (inflight_q && (held_q == CW'(i))) begin
                asm_d[i] = fifo_data;
            end
        end
        held_cap    = held_q + {{(CW-1){1'b0}}, inflight_q};
        held_d      = held_cap;
        word_done   = (held_cap == WB_CNT);
        flush_ready = flush_pend_q && !inflight_q;

        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        flush_pend_d = flush_pend_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A completed full word always goes out before a pending flush resolves.
        if (word_done) begin
            if (out_free) begin
                out_data_d  = asm_d;
                out_keep_d  = '1;
                out_valid_d = 1'b1;
                held_d      = '0;
            end
        end else if (flush_ready) begin
            if (held_q == '0) begin
                flush_pend_d = 1'b0;
            end else if (out_free) begin
                out_data_d   = part_data;
                out_keep_d   = part_keep;
                out_valid_d  = 1'b1;
                held_d       = '0;
                flush_pend_d = 1'b0;
            end
        end

        if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q        <= '0;
            held_q       <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            held_q       <= held_d;
            inflight_q   <= fifo_rd_en;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural upstream FIFO, scoreboard of expected
// output words, plus targeted checks on pop pacing, flush and reset behaviour.
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_data = '0;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;

    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  fifo_q[$];
    int          fifo_cnt = 0;
    int          pop_total = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_words = 0;

    fifo_word_packer #(.DATA_WIDTH(8), .WORD_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fifo_cnt == 0);

    // Upstream synchronous FIFO: data_out registered on a pop.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_data <= fifo_q.pop_front();
            pop_total <= pop_total + 1;
        end
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_cnt <= fifo_q.size();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_words++;
            $display("word %0d: data=0x%08h keep=%b", n_words, out_data, out_keep);
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("word_data", out_data, e.data);
                check("word_keep", {28'd0, out_keep}, {28'd0, e.keep});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.data = d;
        e.keep = k;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            tick();
            k++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        int rd_cycles, rises, first_v, p0, w0;
        logic prev;

        // Reset state
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_keep", {28'd0, out_keep}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // Two full words with continuous reads
        expect_word(32'h68676665, 4'hF);
        expect_word(32'h6C6B6A69, 4'hF);
        rd_cycles = 0; rises = 0; first_v = -1; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr_en   = (i < 8);
            wr_data = 8'd101 + 8'(i);
            @(negedge clk);
            if (fifo_rd_en) rd_cycles++;
            if (fifo_rd_en && !prev) rises++;
            prev = fifo_rd_en;
            if (out_valid && first_v < 0) first_v = i;
            tick();
        end
        wr_en = 1'b0;
        wait_drain("t1_drain", 20);
        check("t1_rd_cycles", rd_cycles, 32'd8);
        check("t1_rd_runs", rises, 32'd1);
        check("t1_first_latency", first_v, 32'd6);

        // Backpressure: reads stop after two words' worth, then resume
        out_ready = 1'b0;
        p0 = pop_total;
        for (int w = 0; w < 4; w++) begin
            expect_word({8'd104 + 8'(4*w), 8'd103 + 8'(4*w), 8'd102 + 8'(4*w), 8'd101 + 8'(4*w)}, 4'hF);
        end
        push_seq(8'd101, 16);
        idle(6);
        @(negedge clk);
        check("t2_pops_stalled", pop_total - p0, 32'd8);
        check("t2_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
        check("t2_fifo_cnt", fifo_cnt, 32'd8);
        check("t2_valid_held", {31'd0, out_valid}, 32'd1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_rd_resume", {31'd0, fifo_rd_en}, 32'd1);
        wait_drain("t2_drain", 40);
        idle(2);
        check("t2_pops_total", pop_total - p0, 32'd16);
        check("t2_fifo_empty", fifo_cnt, 32'd0);

        // Partial-word flush with latency check
        push_seq(8'hA0, 3);
        idle(5);
        expect_word(32'h00A2A1A0, 4'b0111);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t3_valid_t1", {31'd0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("t3_valid_t2", {31'd0, out_valid}, 32'd1);
        wait_drain("t3_drain", 10);

        // Flush with nothing held
        idle(2);
        w0 = n_words;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_no_valid", {31'd0, out_valid}, 32'd0);
            if (k == 1) check("t4_pend_clear", {31'd0, dut.flush_pend_q}, 32'd0);
            tick();
        end
        check("t4_no_word", n_words - w0, 32'd0);
        expect_word(32'h44434241, 4'hF);
        push_seq(8'h41, 4);
        wait_drain("t4_resume_drain", 20);
        idle(2);

        // Flush in the cycle the fourth byte is captured
        w0 = n_words;
        expect_word(32'h34333231, 4'hF);
        for (int i = 0; i < 10; i++) begin
            wr_en   = (i < 4);
            wr_data = 8'h31 + 8'(i);
            flush   = (i == 5);
            @(negedge clk);
            tick();
        end
        wr_en = 1'b0;
        flush = 1'b0;
        idle(6);
        check("t5_sb_empty", exp_q.size(), 32'd0);
        check("t5_one_word", n_words - w0, 32'd1);
        check("t5_pend_clear", {31'd0, dut.flush_pend_q}, 32'd0);

        // Reset with bytes held and a word waiting at the output
        out_ready = 1'b0;
        push_seq(8'h11, 6);
        idle(6);
        @(negedge clk);
        check("t6_valid_before", {31'd0, out_valid}, 32'd1);
        check("t6_held_before", {29'd0, dut.held_q}, 32'd2);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_data", out_data, 32'd0);
        check("t6_rst_keep", {28'd0, out_keep}, 32'd0);
        check("t6_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_word(32'h24232221, 4'hF);
        push_seq(8'h21, 4);
        wait_drain("t6_drain", 20);

        idle(4);
        check("final_sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
